// File: rtl/uart_alu_ctrl_if.sv
// rtl/uart_alu_ctrl_if.sv - UART stream and multiplier handshake bundle for uart_alu_ctrl
interface uart_alu_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] rx_tdata_i;
    logic                  rx_tvalid_i;
    logic                  rx_tready_o;
    logic [DATA_WIDTH-1:0] tx_tdata_o;
    logic                  tx_tvalid_o;
    logic                  tx_tready_i;
    logic [WORD_WIDTH-1:0] mul_a_o;
    logic [WORD_WIDTH-1:0] mul_b_o;
    logic                  mul_valid_o;
    logic                  mul_ready_i;
    logic                  mul_done_i;
    logic [WORD_WIDTH-1:0] mul_p_i;

    modport master (
        input  rx_tdata_i, rx_tvalid_i, tx_tready_i, mul_ready_i, mul_done_i, mul_p_i,
        output rx_tready_o, tx_tdata_o, tx_tvalid_o, mul_a_o, mul_b_o, mul_valid_o
    );

    modport slave (
        output rx_tdata_i, rx_tvalid_i, tx_tready_i, mul_ready_i, mul_done_i, mul_p_i,
        input  rx_tready_o, tx_tdata_o, tx_tvalid_o, mul_a_o, mul_b_o, mul_valid_o
    );
endinterface

// File: rtl/uart_alu_ctrl.sv
// rtl/uart_alu_ctrl.sv - packet parser sequencing echo, add and multiply between UART streams
module uart_alu_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    uart_alu_ctrl_if.master bus,
    output logic            busy_o,
    output logic            err_o
);
    localparam int NB = WORD_WIDTH / DATA_WIDTH;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [7:0] OP_ECHO = 8'h8A;
    localparam logic [7:0] OP_ADD  = 8'hA8;
    localparam logic [7:0] OP_MUL  = 8'hB6;

    typedef enum logic [2:0] {
        S_HDR, S_ECHO, S_ACC, S_MUL_REQ, S_MUL_WAIT, S_SEND, S_DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            hdr_cnt_q, hdr_cnt_d;
    logic [7:0]            op_q, op_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [15:0]           rem_q, rem_d;
    logic [CW-1:0]         byte_cnt_q, byte_cnt_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic [WORD_WIDTH-1:0] acc_q, acc_d;
    logic                  first_q, first_d;
    logic                  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] tx_tdata_q, tx_tdata_d;
    logic                  tx_tvalid_q, tx_tvalid_d;
    logic                  rx_tready_q, rx_tready_d;
    logic                  mul_valid_q, mul_valid_d;
    logic [WORD_WIDTH-1:0] mul_a_q, mul_a_d;
    logic [WORD_WIDTH-1:0] mul_b_q, mul_b_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    logic        rx_fire, tx_fire;
    logic [15:0] hdr_len, hdr_rem;

    assign rx_fire = bus.rx_tvalid_i & rx_tready_q;
    assign tx_fire = tx_tvalid_q & bus.tx_tready_i;
    assign hdr_len = {bus.rx_tdata_i, len_lo_q};
    assign hdr_rem = hdr_len - 16'd4;

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        op_d        = op_q;
        len_lo_d    = len_lo_q;
        rem_d       = rem_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        acc_d       = acc_q;
        first_d     = first_q;
        pend_d      = pend_q;
        tx_tdata_d  = tx_tdata_q;
        tx_tvalid_d = tx_tvalid_q;
        mul_valid_d = mul_valid_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        err_d       = 1'b0;

        case (state_q)
            S_HDR: begin
                if (rx_fire) begin
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'd0) op_d = bus.rx_tdata_i;
                    if (hdr_cnt_q == 2'd2) len_lo_d = bus.rx_tdata_i;
                    if (hdr_cnt_q == 2'd3) begin
                        rem_d      = hdr_rem;
                        byte_cnt_d = '0;
                        first_d    = 1'b1;
                        pend_d     = 1'b0;
                        if (hdr_len < 16'd4) begin
                            err_d = 1'b1;
                            rem_d = '0;
                        end else if (op_q == OP_ECHO) begin
                            if (hdr_rem != 16'd0) state_d = S_ECHO;
                        end else if (op_q == OP_ADD || op_q == OP_MUL) begin
                            if (hdr_rem == 16'd0 || (hdr_rem % 16'(NB)) != 16'd0) begin
                                err_d = 1'b1;
                                if (hdr_rem != 16'd0) state_d = S_DRAIN;
                            end else begin
                                state_d = S_ACC;
                            end
                        end else begin
                            err_d = 1'b1;
                            if (hdr_rem != 16'd0) state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_ECHO: begin
                if (tx_fire) tx_tvalid_d = 1'b0;
                if (rx_fire) begin
                    tx_tdata_d  = bus.rx_tdata_i;
                    tx_tvalid_d = 1'b1;
                    rem_d       = rem_q - 16'd1;
                end
                if (rem_d == 16'd0 && !tx_tvalid_d) state_d = S_HDR;
            end
            S_ACC: begin
                // A pending add spends one cycle folding the last assembled word into the accumulator.
                if (pend_q) begin
                    acc_d  = acc_q + word_q;
                    pend_d = 1'b0;
                    if (rem_q == 16'd0) begin
                        state_d     = S_SEND;
                        tx_tvalid_d = 1'b1;
                        tx_tdata_d  = acc_d[DATA_WIDTH-1:0];
                    end
                end else if (rx_fire) begin
                    word_d     = {bus.rx_tdata_i, word_q[WORD_WIDTH-1:DATA_WIDTH]};
                    rem_d      = rem_q - 16'd1;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == CW'(NB - 1)) begin
                        first_d = 1'b0;
                        if (first_q) begin
                            acc_d = word_d;
                            if (rem_d == 16'd0) begin
                                state_d     = S_SEND;
                                tx_tvalid_d = 1'b1;
                                tx_tdata_d  = acc_d[DATA_WIDTH-1:0];
                            end
                        end else if (op_q == OP_MUL) begin
                            state_d     = S_MUL_REQ;
                            mul_valid_d = 1'b1;
                            mul_a_d     = acc_q;
                            mul_b_d     = word_d;
                        end else begin
                            pend_d = 1'b1;
                        end
                    end
                end
            end
            S_MUL_REQ: begin
                if (bus.mul_ready_i) begin
                    mul_valid_d = 1'b0;
                    state_d     = S_MUL_WAIT;
                end
            end
            S_MUL_WAIT: begin
                if (bus.mul_done_i) begin
                    acc_d = bus.mul_p_i;
                    if (rem_q == 16'd0) begin
                        state_d     = S_SEND;
                        tx_tvalid_d = 1'b1;
                        tx_tdata_d  = acc_d[DATA_WIDTH-1:0];
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end
            S_SEND: begin
                if (tx_fire) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == CW'(NB - 1)) begin
                        tx_tvalid_d = 1'b0;
                        state_d     = S_HDR;
                    end else begin
                        tx_tdata_d = acc_q[{byte_cnt_d, 3'b000} +: DATA_WIDTH];
                    end
                end
            end
            S_DRAIN: begin
                if (rx_fire) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_d == 16'd0) state_d = S_HDR;
                end
            end
            default: state_d = S_HDR;
        endcase

        case (state_d)
            S_HDR:   rx_tready_d = 1'b1;
            S_ECHO:  rx_tready_d = !tx_tvalid_d && (rem_d != 16'd0);
            S_ACC:   rx_tready_d = !pend_d;
            S_DRAIN: rx_tready_d = (rem_d != 16'd0);
            default: rx_tready_d = 1'b0;
        endcase
        busy_d = !(state_d == S_HDR && hdr_cnt_d == 2'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_HDR;
            hdr_cnt_q   <= '0;
            op_q        <= '0;
            len_lo_q    <= '0;
            rem_q       <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            acc_q       <= '0;
            first_q     <= 1'b0;
            pend_q      <= 1'b0;
            tx_tdata_q  <= '0;
            tx_tvalid_q <= 1'b0;
            rx_tready_q <= 1'b0;
            mul_valid_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            op_q        <= op_d;
            len_lo_q    <= len_lo_d;
            rem_q       <= rem_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            acc_q       <= acc_d;
            first_q     <= first_d;
            pend_q      <= pend_d;
            tx_tdata_q  <= tx_tdata_d;
            tx_tvalid_q <= tx_tvalid_d;
            rx_tready_q <= rx_tready_d;
            mul_valid_q <= mul_valid_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign bus.rx_tready_o = rx_tready_q;
    assign bus.tx_tdata_o  = tx_tdata_q;
    assign bus.tx_tvalid_o = tx_tvalid_q;
    assign bus.mul_valid_o = mul_valid_q;
    assign bus.mul_a_o     = mul_a_q;
    assign bus.mul_b_o     = mul_b_q;
    assign busy_o          = busy_q;
    assign err_o           = err_q;
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb/tb_uart_alu_ctrl.sv - self-checking bench for uart_alu_ctrl
module tb_uart_alu_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy_o, err_o;

    uart_alu_ctrl_if bus ();

    uart_alu_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .busy_o (busy_o),
        .err_o  (err_o)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  pkt[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  got_tx[$];
    logic [63:0] exp_mul[$];
    int          err_seen = 0;
    int          mul_reqs = 0;
    bit          tx_rand = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout/unexpected event, expected none", name);
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    // Reference: response bytes, error count and multiplier requests straight from the packet rules.
    task automatic model_pkt();
        int len, rem;
        logic [31:0] acc, w;
        acc = '0;
        len = int'({pkt[3], pkt[2]});
        if (len < 4) return;
        rem = len - 4;
        if (pkt[0] == 8'hA8 || pkt[0] == 8'hB6) begin
            if (rem == 0 || rem % 4 != 0) return;
            for (int k = 0; k < rem / 4; k++) begin
                w = {pkt[4*k+7], pkt[4*k+6], pkt[4*k+5], pkt[4*k+4]};
                if (k == 0) acc = w;
                else if (pkt[0] == 8'hA8) acc = acc + w;
                else begin
                    exp_mul.push_back({acc, w});
                    acc = acc * w;
                end
            end
            for (int i = 0; i < 4; i++) exp_tx.push_back(acc[8*i +: 8]);
        end else if (pkt[0] == 8'h8A) begin
            for (int i = 4; i < len; i++) exp_tx.push_back(pkt[i]);
        end
    endtask

    task automatic send_raw();
        int n;
        foreach (pkt[i]) begin
            bus.rx_tdata_i  = pkt[i];
            bus.rx_tvalid_i = 1'b1;
            n = 0;
            while (!bus.rx_tready_o && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (n >= 300) begin
                fail("rx_accept_timeout");
                break;
            end
            @(negedge clk);
        end
        bus.rx_tvalid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_tx.size() != 0 || busy_o) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) fail("idle_timeout");
        repeat (3) @(negedge clk);
    endtask

    task automatic run_pkt();
        model_pkt();
        send_raw();
        wait_idle();
    endtask

    function automatic logic [31:0] got_word();
        logic [31:0] r = '0;
        for (int i = 0; i < got_tx.size() && i < 4; i++) r[8*i +: 8] = got_tx[i];
        return r;
    endfunction

    // Compare process: every TX handshake against the model, plus hold-under-backpressure.
    initial begin
        bit         stall = 1'b0;
        logic [7:0] stall_data = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("tx_hold_valid", bus.tx_tvalid_o, 1'b1);
                    chk("tx_hold_data", bus.tx_tdata_o, stall_data);
                end
                if (err_o) err_seen++;
                if (bus.tx_tvalid_o && bus.tx_tready_i) begin
                    got_tx.push_back(bus.tx_tdata_o);
                    if (exp_tx.size() == 0) fail("tx_unexpected");
                    else chk("tx_byte", bus.tx_tdata_o, exp_tx.pop_front());
                end
                stall      = bus.tx_tvalid_o && !bus.tx_tready_i;
                stall_data = bus.tx_tdata_o;
            end
        end
    end

    initial begin
        bus.tx_tready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_tready_i = tx_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Multiplier stub: ready after two waiting cycles, done pulse three cycles after acceptance.
    initial begin
        int          st = 0;
        int          w = 0;
        logic [31:0] pa = '0, pb = '0;
        bus.mul_ready_i = 1'b0;
        bus.mul_done_i  = 1'b0;
        bus.mul_p_i     = '0;
        forever begin
            @(negedge clk);
            bus.mul_ready_i = 1'b0;
            bus.mul_done_i  = 1'b0;
            if (!rst) begin
                st = 0;
                w  = 0;
            end else if (st == 0) begin
                if (bus.mul_valid_o) begin
                    w++;
                    if (w == 3) begin
                        bus.mul_ready_i = 1'b1;
                        pa = bus.mul_a_o;
                        pb = bus.mul_b_o;
                        mul_reqs++;
                        if (exp_mul.size() == 0) fail("mul_unexpected");
                        else chk("mul_operands", {pa, pb}, exp_mul.pop_front());
                        st = 1;
                        w  = 0;
                    end
                end
            end else begin
                w++;
                if (w == 3) begin
                    bus.mul_done_i = 1'b1;
                    bus.mul_p_i    = pa * pb;
                    st = 0;
                    w  = 0;
                end
            end
        end
    end

    initial begin
        #600000;
        fail("global_timeout");
        summary();
        $finish;
    end

    initial begin
        int e0, m0;
        bus.rx_tvalid_i = 1'b0;
        bus.rx_tdata_i  = '0;
        repeat (3) @(negedge clk);
        chk("rst_rx_tready", bus.rx_tready_o, 1'b0);
        chk("rst_tx_tvalid", bus.tx_tvalid_o, 1'b0);
        chk("rst_tx_tdata", bus.tx_tdata_o, 8'h00);
        chk("rst_mul_valid", bus.mul_valid_o, 1'b0);
        chk("rst_mul_ab", {bus.mul_a_o, bus.mul_b_o}, 64'h0);
        chk("rst_busy_err", {busy_o, err_o}, 2'b00);
        rst = 1'b1;
        @(negedge clk);
        chk("rx_tready_after_reset", bus.rx_tready_o, 1'b1);

        e0 = err_seen;
        pkt = '{8'h8A, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42};
        run_pkt();
        chk("echo_cnt", got_tx.size(), 2);
        chk("echo_tx", got_word(), 32'h0000_4241);
        chk("echo_err", err_seen - e0, 0);
        chk("echo_busy_low", busy_o, 1'b0);
        got_tx.delete();

        pkt = '{8'hA8, 8'h00, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
        run_pkt();
        chk("add3_tx", {got_tx.size(), got_word()}, {32'd4, 32'h0000_0006});
        got_tx.delete();

        pkt = '{8'hA8, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                8'h02, 8'h00, 8'h00, 8'h00};
        model_pkt();
        send_raw();
        chk("add_lat_pend", bus.tx_tvalid_o, 1'b0);
        @(negedge clk);
        chk("add_lat_first", bus.tx_tvalid_o, 1'b1);
        wait_idle();
        chk("add_wrap_tx", {got_tx.size(), got_word()}, {32'd4, 32'h0000_0001});
        got_tx.delete();

        m0 = mul_reqs;
        pkt = '{8'hA8, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        model_pkt();
        send_raw();
        chk("add1_lat", bus.tx_tvalid_o, 1'b1);
        wait_idle();
        chk("add1_tx", got_word(), 32'h1234_5678);
        got_tx.delete();

        pkt = '{8'hB6, 8'h00, 8'h08, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00};
        run_pkt();
        chk("mul1_tx", got_word(), 32'h0000_0009);
        chk("mul1_no_req", mul_reqs - m0, 0);
        got_tx.delete();

        m0 = mul_reqs;
        pkt = '{8'hB6, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
                8'h05, 8'h00, 8'h00, 8'h00};
        run_pkt();
        chk("mul_tx", {got_tx.size(), got_word()}, {32'd4, 32'h0000_000F});
        chk("mul_req_cnt", mul_reqs - m0, 1);
        got_tx.delete();

        e0 = err_seen;
        pkt = '{8'h11, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
        run_pkt();
        chk("badop_err", err_seen - e0, 1);
        chk("badop_no_tx", got_tx.size(), 0);

        e0 = err_seen;
        pkt = '{8'hA8, 8'h00, 8'h05, 8'h00, 8'hCC};
        run_pkt();
        chk("badlen_err", err_seen - e0, 1);
        chk("badlen_no_tx", got_tx.size(), 0);

        pkt = '{8'h8A, 8'h00, 8'h05, 8'h00, 8'h7E};
        run_pkt();
        chk("followup_echo", {got_tx.size(), got_word()}, {32'd1, 32'h0000_007E});
        got_tx.delete();

        e0 = err_seen;
        pkt = '{8'h8A, 8'h00, 8'h02, 8'h00};
        run_pkt();
        chk("short_len_err", err_seen - e0, 1);
        e0 = err_seen;
        pkt = '{8'h8A, 8'h00, 8'h04, 8'h00};
        run_pkt();
        chk("empty_echo_err", err_seen - e0, 0);
        chk("empty_echo_tx", got_tx.size(), 0);

        tx_rand = 1'b1;
        pkt = '{8'hA8, 8'h00, 8'h10, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h10};
        run_pkt();
        chk("bp_add_tx", {got_tx.size(), got_word()}, {32'd4, 32'h2223_3445});
        got_tx.delete();
        m0 = mul_reqs;
        pkt = '{8'hB6, 8'h00, 8'h10, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
                8'h03, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        run_pkt();
        chk("bp_mul_tx", {got_tx.size(), got_word()}, {32'd4, 32'h0000_002A});
        chk("bp_mul_reqs", mul_reqs - m0, 2);
        got_tx.delete();
        tx_rand = 1'b0;

        pkt = '{8'hA8, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02};
        send_raw();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_rx_tready", bus.rx_tready_o, 1'b0);
        chk("mid_rst_tx", {bus.tx_tvalid_o, bus.tx_tdata_o}, 9'h000);
        chk("mid_rst_mul", {bus.mul_valid_o, bus.mul_a_o, bus.mul_b_o}, 65'h0);
        chk("mid_rst_busy_err", {busy_o, err_o}, 2'b00);
        exp_tx.delete();
        exp_mul.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pkt = '{8'h8A, 8'h00, 8'h07, 8'h00, 8'h01, 8'h02, 8'h03};
        run_pkt();
        chk("post_rst_echo", {got_tx.size(), got_word()}, {32'd3, 32'h0003_0201});
        chk("final_idle", busy_o, 1'b0);

        summary();
        $finish;
    end
endmodule
